// File: rtl/seq_gen.sv
// Serial pattern transmitter: shifts a 1..MAX_LEN bit frame out MSB-first and keeps
// a running reference count of "110" occurrences seen on its own serial output.
module seq_gen #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5,
    parameter int CNT_W   = 8
) (
    input  logic               Clock,
    input  logic               reset,
    input  logic               start,
    input  logic [MAX_LEN-1:0] frame_data,
    input  logic [LEN_W-1:0]   frame_len,
    input  logic               clr_count,
    output logic               data_out,
    output logic               valid,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [CNT_W-1:0]   exp_det_count,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t             state, state_n;
    logic [MAX_LEN-1:0] shreg, shreg_n, aligned;
    logic [LEN_W-1:0]   bit_cnt, bit_cnt_n, shamt;
    logic               data_n, valid_n, busy_n, done_n, err_n;
    logic [1:0]         hist, hist_n;
    logic [CNT_W-1:0]   count_n;
    logic               len_ok, match;

    // Shift amount is only formed for a legal length so it never underflows.
    assign len_ok  = (frame_len != '0) && (frame_len <= MAX_LEN_W);
    assign shamt   = len_ok ? (MAX_LEN_W - frame_len) : '0;
    assign aligned = frame_data << shamt;

    // hist[1] is the line two cycles back, hist[0] one cycle back.
    assign match     = hist[1] & hist[0] & ~data_out;
    assign dbg_state = state;

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        data_n    = data_out;
        valid_n   = valid;
        busy_n    = busy;
        done_n    = 1'b0;
        err_n     = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (start) begin
                    if (len_ok) begin
                        shreg_n   = aligned;
                        data_n    = aligned[MAX_LEN-1];
                        valid_n   = 1'b1;
                        busy_n    = 1'b1;
                        bit_cnt_n = frame_len - 1'b1;
                        state_n   = SHIFT;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            SHIFT: begin
                // shreg[MAX_LEN-1] is the bit currently on the line.
                if (bit_cnt != '0) begin
                    shreg_n   = shreg << 1;
                    data_n    = shreg[MAX_LEN-2];
                    bit_cnt_n = bit_cnt - 1'b1;
                end else begin
                    data_n  = 1'b0;
                    valid_n = 1'b0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = DONE;
                end
            end
            default: begin
                state_n = IDLE;
                data_n  = 1'b0;
                valid_n = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_comb begin
        hist_n = {hist[0], data_out};
        if (clr_count) begin
            count_n = '0;
        end else if (match && (exp_det_count != CNT_MAX)) begin
            count_n = exp_det_count + 1'b1;
        end else begin
            count_n = exp_det_count;
        end
    end

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            shreg         <= '0;
            bit_cnt       <= '0;
            data_out      <= 1'b0;
            valid         <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            hist          <= '0;
            exp_det_count <= '0;
        end else begin
            state         <= state_n;
            shreg         <= shreg_n;
            bit_cnt       <= bit_cnt_n;
            data_out      <= data_n;
            valid         <= valid_n;
            busy          <= busy_n;
            done          <= done_n;
            err           <= err_n;
            hist          <= hist_n;
            exp_det_count <= count_n;
        end
    end

endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: queued expected bit stream checked by a negedge monitor,
// plus a frame-level "110" count model with saturation.
module tb_seq_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] frame_data = '0;
    logic [4:0]  frame_len = '0;
    logic        clr_count = 1'b0;
    logic        data_out, valid, busy, done, err;
    logic [7:0]  exp_det_count;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int model_cnt = 0;
    int run_len = 0;
    logic done_prev = 1'b0;
    logic [0:0] exp_q[$];
    int len_q[$];

    seq_gen #(.MAX_LEN(16), .LEN_W(5), .CNT_W(8)) dut (
        .Clock(clk), .reset(rst_n), .start(start), .frame_data(frame_data),
        .frame_len(frame_len), .clr_count(clr_count), .data_out(data_out),
        .valid(valid), .busy(busy), .done(done), .err(err),
        .exp_det_count(exp_det_count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // "110" occurrences of one frame on a line that is 0 before and after it.
    function automatic int frame_matches(input logic [15:0] d, input int len);
        int m = 0;
        logic b[$];
        for (int i = len - 1; i >= 0; i--) b.push_back(d[i]);
        b.push_back(1'b0);
        for (int i = 0; i + 2 < b.size(); i++)
            if (b[i] && b[i+1] && !b[i+2]) m++;
        return m;
    endfunction

    task automatic issue(input logic [15:0] d, input int len);
        frame_data = d;
        frame_len  = 5'(len);
        start      = 1'b1;
        if (len >= 1 && len <= 16) begin
            for (int i = len - 1; i >= 0; i--) exp_q.push_back(d[i]);
            len_q.push_back(len);
            model_cnt += frame_matches(d, len);
            if (model_cnt > 255) model_cnt = 255;
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) return;
        end
        check("done_timeout", 0, 1);
    endtask

    task automatic settle_and_check_count(input string name);
        repeat (2) @(posedge clk);
        #1;
        check(name, exp_det_count, model_cnt);
    endtask

    task automatic clear_count();
        clr_count = 1'b1;
        @(posedge clk); #1;
        clr_count = 1'b0;
        model_cnt = 0;
        check("clr_count", exp_det_count, 0);
    endtask

    task automatic illegal_start(input int len);
        frame_data = 16'(($urandom));
        frame_len  = 5'(len);
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("err_pulse", err, 1);
        check("err_busy", busy, 0);
        check("err_valid", valid, 0);
        check("err_data", data_out, 0);
        @(posedge clk); #1;
        check("err_one_cycle", err, 0);
        check("err_count", exp_det_count, model_cnt);
    endtask

    // Monitor: pops expected bits whenever the DUT presents a valid bit.
    always @(negedge clk) begin
        if (!rst_n) begin
            run_len   = 0;
            done_prev = 1'b0;
        end else begin
            if (valid) begin
                if (exp_q.size() == 0) check("unexpected_bit", 1, 0);
                else check("data_out", data_out, exp_q.pop_front());
                check("busy_with_valid", busy, 1);
                run_len++;
            end else begin
                check("idle_line", data_out, 0);
            end
            if (done) begin
                if (len_q.size() == 0) check("done_without_frame", 1, 0);
                else check("valid_run_len", run_len, len_q.pop_front());
                check("busy_at_done", busy, 0);
                run_len = 0;
                if (done_prev) check("done_width", 2, 1);
            end
            done_prev = done;
        end
    end

    initial begin
        logic [15:0] d;
        int len;

        #2 rst_n = 1'b0;
        #2;
        check("rst_data", data_out, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_count", exp_det_count, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Mixed frame from reset: four matches.
        issue(16'h1B76, 13);
        wait_done();
        settle_and_check_count("count_1b76");
        check("count_1b76_lit", exp_det_count, 4);

        // Trailing "11" counts one cycle after done.
        clear_count();
        issue(16'h0003, 3);
        wait_done();
        check("count_at_done", exp_det_count, 0);
        @(posedge clk); #1;
        check("count_after_done", exp_det_count, model_cnt);

        // Illegal lengths.
        illegal_start(0);
        illegal_start(17);

        // Start ignored mid-frame, then start accepted during DONE.
        clear_count();
        issue(16'h0036, 6);
        repeat (2) @(posedge clk);
        #1;
        frame_data = 16'hFFFF; frame_len = 5'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        check("count_110110", exp_det_count, 2);
        issue(16'h000B, 4);
        check("done_cycle_start_valid", valid, 1);
        check("done_cycle_start_bit", data_out, 1);
        wait_done();
        settle_and_check_count("count_after_b2b");

        // Asynchronous reset mid-frame.
        issue(16'hA5C3, 16);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        len_q.delete();
        model_cnt = 0;
        #1;
        check("arst_data", data_out, 0);
        check("arst_valid", valid, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_count", exp_det_count, 0);
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        issue(16'h0001, 1);
        wait_done();
        settle_and_check_count("count_after_arst");

        // Randomized frames with occasional illegal or ignored starts.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                illegal_start($urandom_range(0, 1) ? 0 : $urandom_range(17, 31));
            end else begin
                len = $urandom_range(1, 16);
                d   = 16'($urandom);
                issue(d, len);
                if (len >= 4 && $urandom_range(0, 1) == 1) begin
                    @(posedge clk); #1;
                    frame_data = 16'($urandom); frame_len = 5'($urandom_range(0, 31));
                    start = 1'b1;
                    @(posedge clk); #1;
                    start = 1'b0;
                end
                wait_done();
                settle_and_check_count("count_random");
            end
        end

        // Saturation.
        clear_count();
        for (int i = 0; i < 51; i++) begin
            issue(16'hDB6D, 16);
            wait_done();
        end
        settle_and_check_count("count_255");
        issue(16'hDB6D, 16);
        wait_done();
        settle_and_check_count("count_saturated");
        check("count_saturated_lit", exp_det_count, 255);

        // Clear on the same edge as a match wins.
        issue(16'h0006, 3);
        repeat (2) @(posedge clk);
        #1;
        clr_count = 1'b1;
        @(posedge clk); #1;
        clr_count = 1'b0;
        model_cnt = 0;
        check("clr_vs_match_done", done, 1);
        check("clr_vs_match", exp_det_count, 0);
        settle_and_check_count("clr_vs_match_hold");

        repeat (4) @(posedge clk);
        #1;
        check("leftover_bits", exp_q.size(), 0);
        check("leftover_frames", len_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
